// File: rtl/commit_monitor.sv
// commit_monitor
//   Watches the CPU commit stream. Counts retired instructions and cycles,
//   checks that every committed PC equals the next-PC of the previous commit,
//   raises a watchdog error when commits stop, and keeps the last DEPTH
//   commits in a ring buffer that debug logic can read back.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   commit_i        one instruction retires in this cycle
//   commit_pc_i     PC of the retiring instruction
//   commit_pre_pc_i next PC resolved for the retiring instruction
//   clear_i         synchronous clear of counters, errors and trace
//   rd_idx_i        trace read index, 0 = most recent commit
//   rd_pc_o         trace entry PC (one cycle after rd_idx_i)
//   rd_next_pc_o    trace entry next-PC (one cycle after rd_idx_i)
//   rd_valid_o      entry at rd_idx_i holds data (one cycle after rd_idx_i)
//   instr_cnt_o     accepted commit count
//   cycle_cnt_o     cycles spent in IDLE/RUN since reset or clear
//   state_o         0 IDLE, 1 RUN, 2 ERR_FLOW, 3 ERR_TIMEOUT
//   err_pc_o        PC of the commit that broke control flow
//   err_exp_o       PC that was expected when the error was raised
//   max_gap_o       longest no-commit gap seen in RUN
//
// Optional feature macro: COMMIT_MON_GAP_STAT_EN enables the gap statistic;
// without it max_gap_o is constant 0.
//
// Parameters: DEPTH must be a power of 2 and at least 2; TIMEOUT at least 2.
module commit_monitor #(
  parameter int          DEPTH    = 16,
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] PC_RESET = 32'h8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_i,
  input  logic [31:0]              commit_pc_i,
  input  logic [31:0]              commit_pre_pc_i,
  input  logic                     clear_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [31:0]              rd_pc_o,
  output logic [31:0]              rd_next_pc_o,
  output logic                     rd_valid_o,
  output logic [63:0]              instr_cnt_o,
  output logic [63:0]              cycle_cnt_o,
  output logic [1:0]               state_o,
  output logic [31:0]              err_pc_o,
  output logic [31:0]              err_exp_o,
  output logic [15:0]              max_gap_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RUN         = 2'd1,
    ERR_FLOW    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } stateT;

  stateT          state, stateNext;
  logic [31:0]    expectedPc;
  logic           checkFirst;
  logic [AW-1:0]  wptr;
  logic [AW:0]    fillCnt;
  logic [WDW-1:0] watchdog;
  logic [31:0]    memPc   [DEPTH];
  logic [31:0]    memNext [DEPTH];

  logic           active;
  logic           accept;
  logic           flowBad;
  logic           wdHit;
  logic [AW-1:0]  rdAddr;

  assign state_o = state;

  // Error states freeze everything, and clear_i discards a same-cycle commit.
  // In IDLE only the very first commit after reset is checked against
  // PC_RESET; after a clear the first commit is taken on trust.
  // The watchdog fires on the cycle where it would step onto TIMEOUT-1, so a
  // commit in that same cycle still rescues the pipeline.
  always_comb begin
    active    = (state == IDLE) || (state == RUN);
    accept    = commit_i && active && !clear_i;
    flowBad   = (state == IDLE) ? (checkFirst && (commit_pc_i != PC_RESET))
                                : (commit_pc_i != expectedPc);
    wdHit     = active && !commit_i && (watchdog == WDW'(TIMEOUT - 2));
    rdAddr    = wptr - AW'(1) - rd_idx_i;
    stateNext = state;
    if (clear_i)
      stateNext = IDLE;
    else if (accept)
      stateNext = flowBad ? ERR_FLOW : RUN;
    else if (wdHit)
      stateNext = ERR_TIMEOUT;
  end

  // Control state, counters, watchdog and error capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      expectedPc  <= PC_RESET;
      checkFirst  <= 1'b1;
      wptr        <= '0;
      fillCnt     <= '0;
      watchdog    <= '0;
      instr_cnt_o <= '0;
      cycle_cnt_o <= '0;
      err_pc_o    <= '0;
      err_exp_o   <= '0;
    end else begin
      state <= stateNext;
      if (clear_i) begin
        checkFirst  <= 1'b0;
        wptr        <= '0;
        fillCnt     <= '0;
        watchdog    <= '0;
        instr_cnt_o <= '0;
        cycle_cnt_o <= '0;
        err_pc_o    <= '0;
        err_exp_o   <= '0;
      end else begin
        if (active)
          cycle_cnt_o <= cycle_cnt_o + 64'd1;
        if (accept) begin
          instr_cnt_o <= instr_cnt_o + 64'd1;
          watchdog    <= '0;
          expectedPc  <= commit_pre_pc_i;
          wptr        <= wptr + AW'(1);
          if (fillCnt != (AW+1)'(DEPTH))
            fillCnt <= fillCnt + (AW+1)'(1);
          if (flowBad) begin
            err_pc_o  <= commit_pc_i;
            err_exp_o <= (state == IDLE) ? PC_RESET : expectedPc;
          end
        end else if (active) begin
          watchdog <= watchdog + WDW'(1);
          if (wdHit)
            err_exp_o <= expectedPc;
        end
      end
    end
  end

  // Trace storage has no reset; fillCnt decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      memPc[wptr]   <= commit_pc_i;
      memNext[wptr] <= commit_pre_pc_i;
    end
  end

  // Registered read port; reading the slot being written returns old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pc_o      <= '0;
      rd_next_pc_o <= '0;
      rd_valid_o   <= 1'b0;
    end else begin
      rd_pc_o      <= memPc[rdAddr];
      rd_next_pc_o <= memNext[rdAddr];
      rd_valid_o   <= ({1'b0, rd_idx_i} < fillCnt);
    end
  end

`ifdef COMMIT_MON_GAP_STAT_EN
  logic [15:0] gapCnt;

  // Longest run of idle cycles between two commits, measured in RUN only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gapCnt    <= '0;
      max_gap_o <= '0;
    end else if (clear_i) begin
      gapCnt    <= '0;
      max_gap_o <= '0;
    end else if (state == RUN) begin
      if (accept) begin
        if (gapCnt > max_gap_o)
          max_gap_o <= gapCnt;
        gapCnt <= '0;
      end else if (gapCnt != 16'hFFFF) begin
        gapCnt <= gapCnt + 16'd1;
      end
    end
  end
`else
  assign max_gap_o = '0;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// tb_commit_monitor
//   Self-checking bench for commit_monitor. Instance dutA (DEPTH=4, TIMEOUT=8)
//   covers flow checking, timeout and the trace ring; instance dutB
//   (DEPTH=16, TIMEOUT=64) shares the same inputs and is used where long idle
//   gaps are needed. Trace reads go through a queue of expected entries.
module tb_commit_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commitI = 1'b0;
  logic [31:0] commitPc = '0;
  logic [31:0] commitPrePc = '0;
  logic        clearI = 1'b0;
  logic [3:0]  rdIdx = '0;

  logic [31:0] aRdPc, aRdNext, aErrPc, aErrExp, bRdPc, bRdNext, bErrPc, bErrExp;
  logic        aRdValid, bRdValid;
  logic [63:0] aInstr, aCycle, bInstr, bCycle;
  logic [1:0]  aState, bState;
  logic [15:0] aMaxGap, bMaxGap;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] npc;
  } rdExpT;
  rdExpT rdQ[$];

  always #5 clk = ~clk;

  commit_monitor #(.DEPTH(4), .TIMEOUT(8)) dutA (
    .clk(clk), .rst(rst), .commit_i(commitI), .commit_pc_i(commitPc),
    .commit_pre_pc_i(commitPrePc), .clear_i(clearI), .rd_idx_i(rdIdx[1:0]),
    .rd_pc_o(aRdPc), .rd_next_pc_o(aRdNext), .rd_valid_o(aRdValid),
    .instr_cnt_o(aInstr), .cycle_cnt_o(aCycle), .state_o(aState),
    .err_pc_o(aErrPc), .err_exp_o(aErrExp), .max_gap_o(aMaxGap)
  );

  commit_monitor #(.DEPTH(16), .TIMEOUT(64)) dutB (
    .clk(clk), .rst(rst), .commit_i(commitI), .commit_pc_i(commitPc),
    .commit_pre_pc_i(commitPrePc), .clear_i(clearI), .rd_idx_i(rdIdx),
    .rd_pc_o(bRdPc), .rd_next_pc_o(bRdNext), .rd_valid_o(bRdValid),
    .instr_cnt_o(bInstr), .cycle_cnt_o(bCycle), .state_o(bState),
    .err_pc_o(bErrPc), .err_exp_o(bErrExp), .max_gap_o(bMaxGap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commitOne(input logic [31:0] pc, input logic [31:0] npc);
    commitI     = 1'b1;
    commitPc    = pc;
    commitPrePc = npc;
    tick();
    commitI = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulseReset();
    commitI = 1'b0;
    clearI  = 1'b0;
    rst     = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic pulseClear();
    clearI = 1'b1;
    tick();
    clearI = 1'b0;
  endtask

  // Drive a read index and queue the entry expected one cycle later.
  task automatic driveRead(input int idx, input logic v, input logic [31:0] pc);
    rdExpT e;
    e.valid = v;
    e.pc    = pc;
    e.npc   = pc + 32'd4;
    rdIdx   = 4'(idx);
    rdQ.push_back(e);
    tick();
  endtask

  task automatic test_reset();
    commitI = 1'b0;
    clearI  = 1'b0;
    rst     = 1'b0;
    tick();
    total += 8;
    if (aState !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", aState); end
    if (aInstr !== 64'd0) begin bad++; $display("FAIL reset_instr got=%0d want=0", aInstr); end
    if (aCycle !== 64'd0) begin bad++; $display("FAIL reset_cycle got=%0d want=0", aCycle); end
    if (aErrPc !== 32'd0) begin bad++; $display("FAIL reset_errpc got=%h want=0", aErrPc); end
    if (aErrExp !== 32'd0) begin bad++; $display("FAIL reset_errexp got=%h want=0", aErrExp); end
    if (aRdValid !== 1'b0) begin bad++; $display("FAIL reset_rdvalid got=%b want=0", aRdValid); end
    if (aRdPc !== 32'd0) begin bad++; $display("FAIL reset_rdpc got=%h want=0", aRdPc); end
    if (bMaxGap !== 16'd0) begin bad++; $display("FAIL reset_maxgap got=%0d want=0", bMaxGap); end
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    rdExpT e;
    logic [31:0] pcTab [3] = '{32'h8000_0008, 32'h8000_0000, 32'h0};
    logic        vTab  [3] = '{1'b1, 1'b1, 1'b0};
    int          idxTab[3] = '{0, 2, 3};
    pulseReset();
    for (int i = 0; i < 3; i++) commitOne(32'h8000_0000 + 32'(4*i), 32'h8000_0004 + 32'(4*i));
    total += 2;
    if (aState !== 2'd1) begin bad++; $display("FAIL seq_state got=%0d want=1", aState); end
    if (aInstr !== 64'd3) begin bad++; $display("FAIL seq_instr got=%0d want=3", aInstr); end
    for (int i = 0; i < 3; i++) begin
      driveRead(idxTab[i], vTab[i], pcTab[i]);
      e = rdQ.pop_front();
      total++;
      if (aRdValid !== e.valid || (e.valid && (aRdPc !== e.pc || aRdNext !== e.npc))) begin
        bad++;
        $display("FAIL seq_read%0d got=%b/%h/%h want=%b/%h/%h", idxTab[i], aRdValid, aRdPc, aRdNext, e.valid, e.pc, e.npc);
      end
    end
  endtask

  task automatic test_first_bad();
    rdExpT e;
    pulseReset();
    commitOne(32'h8000_0010, 32'h8000_0014);
    total += 4;
    if (aState !== 2'd2) begin bad++; $display("FAIL first_state got=%0d want=2", aState); end
    if (aErrPc !== 32'h8000_0010) begin bad++; $display("FAIL first_errpc got=%h want=80000010", aErrPc); end
    if (aErrExp !== 32'h8000_0000) begin bad++; $display("FAIL first_errexp got=%h want=80000000", aErrExp); end
    if (aInstr !== 64'd1) begin bad++; $display("FAIL first_instr got=%0d want=1", aInstr); end
    driveRead(0, 1'b1, 32'h8000_0010);
    e = rdQ.pop_front();
    total++;
    if (aRdValid !== e.valid || aRdPc !== e.pc) begin
      bad++; $display("FAIL first_trace got=%b/%h want=%b/%h", aRdValid, aRdPc, e.valid, e.pc);
    end
    commitOne(32'h8000_0014, 32'h8000_0018);
    commitOne(32'h8000_0018, 32'h8000_001C);
    total += 3;
    if (aInstr !== 64'd1) begin bad++; $display("FAIL first_sticky_instr got=%0d want=1", aInstr); end
    if (aState !== 2'd2) begin bad++; $display("FAIL first_sticky_state got=%0d want=2", aState); end
    if (aErrPc !== 32'h8000_0010) begin bad++; $display("FAIL first_sticky_errpc got=%h want=80000010", aErrPc); end
  endtask

  task automatic test_flow_break();
    pulseReset();
    commitOne(32'h8000_0000, 32'h8000_0100);
    commitOne(32'h8000_0004, 32'h8000_0008);
    total += 4;
    if (aState !== 2'd2) begin bad++; $display("FAIL flow_state got=%0d want=2", aState); end
    if (aErrExp !== 32'h8000_0100) begin bad++; $display("FAIL flow_errexp got=%h want=80000100", aErrExp); end
    if (aErrPc !== 32'h8000_0004) begin bad++; $display("FAIL flow_errpc got=%h want=80000004", aErrPc); end
    if (aInstr !== 64'd2) begin bad++; $display("FAIL flow_instr got=%0d want=2", aInstr); end
  endtask

  task automatic test_timeout();
    pulseReset();
    pulseClear();
    commitOne(32'h8000_0000, 32'h8000_0004);
    idleCycles(7);
    total += 3;
    if (aState !== 2'd3) begin bad++; $display("FAIL to_state got=%0d want=3", aState); end
    if (aCycle !== 64'd8) begin bad++; $display("FAIL to_cycle got=%0d want=8", aCycle); end
    if (aErrExp !== 32'h8000_0004) begin bad++; $display("FAIL to_errexp got=%h want=80000004", aErrExp); end
    idleCycles(5);
    total++;
    if (aCycle !== 64'd8) begin bad++; $display("FAIL to_frozen got=%0d want=8", aCycle); end
    pulseClear();
    commitOne(32'h8000_0000, 32'h8000_0004);
    idleCycles(6);
    commitOne(32'h8000_0004, 32'h8000_0008);
    total += 3;
    if (aState !== 2'd1) begin bad++; $display("FAIL to_rescue_state got=%0d want=1", aState); end
    if (aInstr !== 64'd2) begin bad++; $display("FAIL to_rescue_instr got=%0d want=2", aInstr); end
    if (aCycle !== 64'd8) begin bad++; $display("FAIL to_rescue_cycle got=%0d want=8", aCycle); end
  endtask

  task automatic test_ring_clear();
    rdExpT e;
    logic [31:0] pcTab [4] = '{32'h8000_0014, 32'h8000_0010, 32'h8000_000C, 32'h8000_0008};
    pulseReset();
    for (int i = 0; i < 6; i++) commitOne(32'h8000_0000 + 32'(4*i), 32'h8000_0004 + 32'(4*i));
    for (int i = 0; i < 4; i++) begin
      driveRead(i, 1'b1, pcTab[i]);
      e = rdQ.pop_front();
      total++;
      if (aRdValid !== e.valid || aRdPc !== e.pc || aRdNext !== e.npc) begin
        bad++;
        $display("FAIL ring_read%0d got=%b/%h/%h want=%b/%h/%h", i, aRdValid, aRdPc, aRdNext, e.valid, e.pc, e.npc);
      end
    end
    clearI      = 1'b1;
    commitI     = 1'b1;
    commitPc    = 32'h8000_0018;
    commitPrePc = 32'h8000_001C;
    tick();
    clearI  = 1'b0;
    commitI = 1'b0;
    total += 2;
    if (aState !== 2'd0) begin bad++; $display("FAIL clear_state got=%0d want=0", aState); end
    if (aInstr !== 64'd0) begin bad++; $display("FAIL clear_instr got=%0d want=0", aInstr); end
    for (int i = 0; i < 4; i++) begin
      driveRead(i, 1'b0, 32'h0);
      e = rdQ.pop_front();
      total++;
      if (aRdValid !== e.valid) begin
        bad++; $display("FAIL clear_valid%0d got=%b want=%b", i, aRdValid, e.valid);
      end
    end
    commitOne(32'h8000_0040, 32'h8000_0044);
    total += 2;
    if (aState !== 2'd1) begin bad++; $display("FAIL clear_first_state got=%0d want=1", aState); end
    if (aInstr !== 64'd1) begin bad++; $display("FAIL clear_first_instr got=%0d want=1", aInstr); end
  endtask

  task automatic test_gap();
    logic [15:0] wantGap;
`ifdef COMMIT_MON_GAP_STAT_EN
    wantGap = 16'd10;
`else
    wantGap = 16'd0;
`endif
    pulseReset();
    commitOne(32'h8000_0000, 32'h8000_0004);
    idleCycles(3);
    commitOne(32'h8000_0004, 32'h8000_0008);
    idleCycles(10);
    commitOne(32'h8000_0008, 32'h8000_000C);
    idleCycles(2);
    commitOne(32'h8000_000C, 32'h8000_0010);
    total += 3;
    if (bMaxGap !== wantGap) begin bad++; $display("FAIL gap_max got=%0d want=%0d", bMaxGap, wantGap); end
    if (bState !== 2'd1) begin bad++; $display("FAIL gap_state got=%0d want=1", bState); end
    if (bInstr !== 64'd4) begin bad++; $display("FAIL gap_instr got=%0d want=4", bInstr); end
    pulseClear();
    total++;
    if (bMaxGap !== 16'd0) begin bad++; $display("FAIL gap_clear got=%0d want=0", bMaxGap); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_first_bad();
    test_flow_break();
    test_timeout();
    test_ring_clear();
    test_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
